// File: rtl/ram_pkg.sv
// Shared types and helpers for the RAM port controller and its storage array.
package ram_pkg;

  // Status reported to the core on ramstate; the FSM state is this value.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Byte address to word index. Callers zero-extend to 64 bits and keep only
  // as many low bits as their storage depth needs.
  function automatic logic [63:0] word_idx(input logic [63:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/ram_port_array.sv
// Synchronous single-port word storage with one write port and a registered
// read port. Contents are not reset; only the read register is.
module ram_port_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; the controller guarantees we and re are never both high.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Registered read data, held between reads so it stays stable for the core.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/ram_port_ctrl.sv
// Memory-side controller for the scheduler core's RAM port: latches the single
// outstanding request, checks legality, models a fixed access latency and
// muxes core and preload writes into the storage array.
//
// state  | meaning
// FREE   | idle; accepts a core request or a preload write
// BUSY   | legal request latched, counting down the access latency
// ACCESS | one-cycle access slot; read data is valid on ramload
// ERROR  | one-cycle report of an illegal request, no side effect
module ram_port_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned LAT    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] memaddr,
  input  logic              memREN,
  input  logic              memWEN,
  input  logic [DATA_W-1:0] memstore,
  output logic [DATA_W-1:0] ramload,
  output logic [1:0]        ramstate,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [3:0]  LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  ramstate_t         state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_ren;
  logic              lat_wen;
  logic [DATA_W-1:0] lat_store;

  logic              req;
  logic              core_bad;
  logic              ld_bad;
  logic              changed;
  logic              go_access;
  logic              ld_ok;
  logic [IDX_W-1:0]  core_idx;
  logic [IDX_W-1:0]  ld_idx;
  logic              arr_we;
  logic              arr_re;
  logic [IDX_W-1:0]  arr_idx;
  logic [DATA_W-1:0] arr_wdata;

  assign req      = memREN | memWEN;
  assign core_idx = IDX_W'(word_idx(64'(memaddr)));
  assign ld_idx   = IDX_W'(word_idx(64'(ld_addr)));

  // An address is usable only if word aligned and inside the backing store.
  assign core_bad = (|memaddr[1:0]) || ((memaddr >> (IDX_W + 2)) != '0) ||
                    (memREN && memWEN);
  assign ld_bad   = (|ld_addr[1:0]) || ((ld_addr >> (IDX_W + 2)) != '0);

  assign changed  = (memaddr != lat_addr) || (memREN != lat_ren) ||
                    (memWEN != lat_wen) || (memstore != lat_store);

  // Preload only when the port is completely idle; otherwise it is dropped.
  assign ld_ok    = ld_en && (state == FREE) && !req && !ld_bad;

  // Decide whether this edge enters ACCESS. In BUSY the live request equals
  // the latched one whenever this fires, so the live fields drive the array.
  always_comb begin
    go_access = 1'b0;
    unique case (state)
      FREE:    go_access = req && !core_bad && (LAT == 0);
      BUSY:    go_access = req && !changed && (cnt == 4'd0);
      default: go_access = 1'b0;
    endcase
  end

  assign arr_we    = (go_access && memWEN) || ld_ok;
  assign arr_re    = go_access && memREN;
  assign arr_idx   = ld_ok ? ld_idx : core_idx;
  assign arr_wdata = ld_ok ? ld_data : memstore;

  ram_port_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .CLK   (CLK),
    .RST   (RST),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (ramload)
  );

  assign ramstate = state;

  // Request FSM with latency counter and request latch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= FREE;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_ren   <= 1'b0;
      lat_wen   <= 1'b0;
      lat_store <= '0;
    end else begin
      unique case (state)
        FREE: begin
          if (req) begin
            lat_addr  <= memaddr;
            lat_ren   <= memREN;
            lat_wen   <= memWEN;
            lat_store <= memstore;
            if (core_bad) begin
              state <= ERROR;
            end else if (LAT == 0) begin
              state <= ACCESS;
            end else begin
              state <= BUSY;
              cnt   <= LAT_M1;
            end
          end
        end
        BUSY: begin
          if (!req) begin
            state <= FREE;
          end else if (changed) begin
            // The core moved its request: start the latency over on the new one.
            lat_addr  <= memaddr;
            lat_ren   <= memREN;
            lat_wen   <= memWEN;
            lat_store <= memstore;
            if (core_bad) begin
              state <= ERROR;
            end else begin
              cnt <= LAT_M1;
            end
          end else if (cnt == 4'd0) begin
            state <= ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACCESS:  state <= FREE;
        ERROR:   state <= FREE;
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: doc/ram_port_ctrl.md
# ram_port_ctrl

Memory-side controller that sits directly downstream of the scheduler core's RAM port. It accepts the core's single outstanding word request (memaddr/memREN/memWEN/memstore) and holds a word-addressed backing store. It models a fixed access latency and returns a registered `ramload` word and a `ramstate` status each cycle. It also owns a bench/boot load port used to preload program and data images before the core leaves reset.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, word width.
- `DEPTH`, 1024, number of words in the backing store; power of two.
- `LAT`, 2, number of BUSY cycles before ACCESS; legal range 0–15.

Ports:
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `memaddr` input ADDR_W: byte address from the core.
- `memREN` input 1: read request.
- `memWEN` input 1: write request.
- `memstore` input DATA_W: write data.
- `ramload` output DATA_W: read data; valid only while `ramstate`==ACCESS after a read.
- `ramstate` output 2: `ramstate_t` status, registered.
- `ld_en` input 1: preload write strobe.
- `ld_addr` input ADDR_W: preload byte address.
- `ld_data` input DATA_W: preload data.

## Operation
- `ramstate_t` encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3. The FSM state drives `ramstate` directly.
- Word index is `addr[$clog2(DEPTH)+1:2]`.
- A request is illegal if any of the following hold:
  - `addr[1:0]` != 0;
  - any address bit above the index is set;
  - `memREN` and `memWEN` are both high.
- FREE, request present:
  - Latch {addr, REN, WEN, store}.
  - Illegal request → ERROR.
  - Legal request with LAT=0 → ACCESS.
  - Legal request otherwise → BUSY, with the counter loaded to LAT-1.
- BUSY:
  - If the live request differs from the latched one in any field, re-latch and reload the counter (restart). This applies even if the new request is illegal; in that case go to ERROR.
  - If the request drops (no REN/WEN), go to FREE.
  - Otherwise decrement the counter. On counter==0, go to ACCESS.
- Entering ACCESS (same edge):
  - A read registers `ramload` <= mem[idx].
  - A write performs mem[idx] <= store; `ramload` is unchanged.
- ACCESS lasts exactly one cycle, then goes to FREE unconditionally. This gives the core one cycle to retire or change its request and prevents double writes.
- ERROR lasts one cycle, then goes to FREE. There is no memory side effect and `ramload` is unchanged.
- Preload port:
  - `ld_en` writes mem[idx(ld_addr)] <= ld_data only while the state is FREE and no core request is present.
  - Otherwise `ld_en` is ignored (dropped, not queued).
  - An out-of-range or misaligned `ld_addr` is ignored.
- Reset:
  - `ramstate`=FREE, `ramload`=0, counter=0, latched request cleared.
  - Memory contents are not reset.
  - Reset during BUSY aborts the request, and a pending write is not performed.

## Timing
- Legal request sampled at edge 0 in FREE: `ramstate`=BUSY for cycles 1..LAT, ACCESS in cycle LAT+1, FREE in cycle LAT+2.
- LAT=0: ACCESS in cycle 1.
- Read data is visible in the same cycle `ramstate` shows ACCESS.
- Back-to-back requests: the minimum period is LAT+2 cycles.
- A write followed by a read to the same address returns the new data.
- `ramload` and `ramstate` are pure flops with no combinational path from the inputs.

## Structure
- `ram_pkg`: `ramstate_t`, default `ADDR_W`/`DATA_W`, and the `word_idx` helper function.
- One sub-module, `ram_port_array`: the synchronous single-port storage.
  - One write port and one registered read port.
  - Writes are muxed between the core and the preload port by the controller.
- The FSM, counter, request latch and legality check live in `ram_port_ctrl`.

## Test plan
- Preload mem[0x40>>2]=0xDEADBEEF; LAT=2; read memaddr=0x40 held → BUSY,BUSY,ACCESS with `ramload`=0xDEADBEEF, then FREE.
- Write 0x12345678 to 0x80, then read 0x80 → read ACCESS returns 0x12345678. Each access takes 4 cycles from request to the following FREE.
- Read 0x10 for one BUSY cycle, then switch to 0x14 → the counter restarts. ACCESS comes LAT cycles after the switch, with mem[5] data.
- Request 0x03 (misaligned), request 0x1000 with DEPTH=1024 (out of range), and REN&WEN together → each gives ERROR for one cycle, then FREE, with memory unchanged.
- Assert RST mid-BUSY on a write of 0xAAAA5555 to 0x20 → `ramstate`=FREE and `ramload`=0 immediately; a subsequent read of 0x20 returns the old preloaded value.
- `ld_en` pulsed during BUSY → ignored. `ld_en` during FREE with no request → the write lands, and a later read confirms it.
